// File: rtl/gru_pkg.sv
// Shared types and constants for the GRU sequencing blocks.
package gru_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    S_READY,
    S_WAIT,
    S_OUT
  } gru_seq_state_t;

  // Default Qm.f split of the cell datapath.
  localparam int unsigned GRU_INT_WIDTH  = 50;
  localparam int unsigned GRU_FRAC_WIDTH = 50;
  localparam int unsigned GRU_WIDTH      = GRU_INT_WIDTH + GRU_FRAC_WIDTH + 1;

  // Fixed-point 1.0 in the default format.
  localparam logic [GRU_WIDTH-1:0] GRU_ONE =
    {{GRU_INT_WIDTH{1'b0}}, 1'b1, {GRU_FRAC_WIDTH{1'b0}}};

  // Latency counter width; covers a cell latency of 0..15.
  localparam int unsigned GRU_LAT_W = 4;

endpackage

// File: rtl/gru_lat_timer.sv
// Loadable down-counter that times the cell latency.
module gru_lat_timer
  import gru_pkg::*;
#(
  parameter int unsigned CELL_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic zero_o
);

  logic [GRU_LAT_W-1:0] cnt_q, cnt_d;

  // Clear beats load; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = GRU_LAT_W'(CELL_LATENCY);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GRU_LAT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gru_seq_ctrl.sv
// Steps a fixed-latency GRU cell across a sequence of x vectors, feeding the
// captured y back as the next hidden state and streaming it out.
module gru_seq_ctrl
  import gru_pkg::*;
#(
  parameter int unsigned INT_WIDTH    = GRU_INT_WIDTH,
  parameter int unsigned FRAC_WIDTH   = GRU_FRAC_WIDTH,
  parameter int unsigned WIDTH        = INT_WIDTH + FRAC_WIDTH + 1,
  parameter int unsigned CELL_LATENCY = 1,
  parameter int unsigned MAX_LEN      = 1024,
  parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_x0_i,
  input  logic [WIDTH-1:0] in_x1_i,
  input  logic             in_last_i,
  input  logic [WIDTH-1:0] h_init0_i,
  input  logic [WIDTH-1:0] h_init1_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] cell_x0_o,
  output logic [WIDTH-1:0] cell_x1_o,
  output logic [WIDTH-1:0] cell_h0_o,
  output logic [WIDTH-1:0] cell_h1_o,
  input  logic [WIDTH-1:0] cell_y0_i,
  input  logic [WIDTH-1:0] cell_y1_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_h0_o,
  output logic [WIDTH-1:0] out_h1_o,
  output logic             out_last_o,
  output logic             seq_done_o,
  output logic             busy_o,
  output logic [LEN_W-1:0] step_count_o,
  output logic             len_err_o
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

  gru_seq_state_t state_q, state_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] cell_x0_q, cell_x0_d, cell_x1_q, cell_x1_d;
  logic [WIDTH-1:0] cell_h0_q, cell_h0_d, cell_h1_q, cell_h1_d;
  logic [WIDTH-1:0] out_h0_q, out_h0_d, out_h1_q, out_h1_d;
  logic             out_last_q, out_last_d;
  logic             seq_done_q, seq_done_d;
  logic [LEN_W-1:0] step_q, step_d;
  logic             len_err_q, len_err_d;

  logic             tmr_load, tmr_zero;
  logic [LEN_W-1:0] step_inc;
  logic             hit_max;

  // Abort suppresses the accept, so the timer is never loaded on an abort cycle.
  assign tmr_load = (state_q == S_READY) && in_valid_i && !abort_i;

  gru_lat_timer #(
    .CELL_LATENCY (CELL_LATENCY)
  ) u_lat_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (tmr_load),
    .dec_i  (state_q == S_WAIT),
    .clr_i  (abort_i),
    .zero_o (tmr_zero)
  );

  assign step_inc = (step_q == MaxLen) ? step_q : step_q + LEN_W'(1);
  assign hit_max  = (step_inc == MaxLen);

  // Next-state and datapath update; abort overrides every handshake.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    last_d     = last_q;
    cell_x0_d  = cell_x0_q;
    cell_x1_d  = cell_x1_q;
    cell_h0_d  = cell_h0_q;
    cell_h1_d  = cell_h1_q;
    out_h0_d   = out_h0_q;
    out_h1_d   = out_h1_q;
    out_last_d = out_last_q;
    seq_done_d = 1'b0;
    step_d     = step_q;
    len_err_d  = len_err_q;

    if (abort_i) begin
      state_d   = S_READY;
      first_d   = 1'b1;
      step_d    = '0;
      len_err_d = 1'b0;
    end else begin
      unique case (state_q)
        S_READY: begin
          if (in_valid_i) begin
            cell_x0_d = in_x0_i;
            cell_x1_d = in_x1_i;
            last_d    = in_last_i;
            if (first_q) begin
              cell_h0_d = h_init0_i;
              cell_h1_d = h_init1_i;
            end
            first_d = 1'b0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (tmr_zero) begin
            out_h0_d   = cell_y0_i;
            out_h1_d   = cell_y1_i;
            cell_h0_d  = cell_y0_i;
            cell_h1_d  = cell_y1_i;
            step_d     = step_inc;
            out_last_d = last_q || hit_max;
            // Sequence cut short by the length limit rather than by in_last.
            if (!last_q && hit_max) begin
              len_err_d = 1'b1;
            end
            state_d = S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            if (out_last_q) begin
              first_d    = 1'b1;
              step_d     = '0;
              seq_done_d = 1'b1;
            end else begin
              first_d = 1'b0;
            end
            state_d = S_READY;
          end
        end
        default: state_d = S_READY;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_READY;
      first_q    <= 1'b1;
      last_q     <= 1'b0;
      cell_x0_q  <= '0;
      cell_x1_q  <= '0;
      cell_h0_q  <= '0;
      cell_h1_q  <= '0;
      out_h0_q   <= '0;
      out_h1_q   <= '0;
      out_last_q <= 1'b0;
      seq_done_q <= 1'b0;
      step_q     <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      last_q     <= last_d;
      cell_x0_q  <= cell_x0_d;
      cell_x1_q  <= cell_x1_d;
      cell_h0_q  <= cell_h0_d;
      cell_h1_q  <= cell_h1_d;
      out_h0_q   <= out_h0_d;
      out_h1_q   <= out_h1_d;
      out_last_q <= out_last_d;
      seq_done_q <= seq_done_d;
      step_q     <= step_d;
      len_err_q  <= len_err_d;
    end
  end

  // in_ready is held low for the whole reset pulse.
  assign in_ready_o   = (state_q == S_READY) && !reset;
  assign out_valid_o  = (state_q == S_OUT);
  assign cell_x0_o    = cell_x0_q;
  assign cell_x1_o    = cell_x1_q;
  assign cell_h0_o    = cell_h0_q;
  assign cell_h1_o    = cell_h1_q;
  assign out_h0_o     = out_h0_q;
  assign out_h1_o     = out_h1_q;
  assign out_last_o   = out_last_q;
  assign seq_done_o   = seq_done_q;
  assign busy_o       = (state_q != S_READY) || !first_q;
  assign step_count_o = step_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Scoreboard bench for gru_seq_ctrl with a registered y = x + h mock cell.
module tb_gru_seq_ctrl;
  import gru_pkg::*;

  localparam int unsigned W   = GRU_WIDTH;
  localparam int unsigned ML  = 4;
  localparam int unsigned LW  = $clog2(ML + 1);
  localparam int unsigned LAT = 1;

  typedef struct {
    logic [W-1:0] h0;
    logic [W-1:0] h1;
    logic         last;
    int           step;
    logic         lerr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_ready, in_last = 1'b0, abort = 1'b0;
  logic [W-1:0]  in_x0 = '0, in_x1 = '0, h_init0 = '0, h_init1 = '0;
  logic [W-1:0]  cell_x0, cell_x1, cell_h0, cell_h1, cell_y0, cell_y1;
  logic          out_valid, out_ready = 1'b0, out_last, seq_done, busy, len_err;
  logic [W-1:0]  out_h0, out_h1;
  logic [LW-1:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  int acc_cyc  = 0;
  logic [W-1:0] last_h0 = '0;

  exp_t q[$];
  exp_t mon_e;
  logic exp_done = 1'b0;
  logic mon_nd;

  // Reference model state: hidden state, first-step flag, step index, sticky error.
  logic [W-1:0] m_h0 = '0, m_h1 = '0;
  logic         m_first = 1'b1;
  int           m_step = 0;
  logic         m_len_err = 1'b0;

  gru_seq_ctrl #(
    .CELL_LATENCY (LAT),
    .MAX_LEN      (ML)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_x0_i      (in_x0),
    .in_x1_i      (in_x1),
    .in_last_i    (in_last),
    .h_init0_i    (h_init0),
    .h_init1_i    (h_init1),
    .abort_i      (abort),
    .cell_x0_o    (cell_x0),
    .cell_x1_o    (cell_x1),
    .cell_h0_o    (cell_h0),
    .cell_h1_o    (cell_h1),
    .cell_y0_i    (cell_y0),
    .cell_y1_i    (cell_y1),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_h0_o     (out_h0),
    .out_h1_o     (out_h1),
    .out_last_o   (out_last),
    .seq_done_o   (seq_done),
    .busy_o       (busy),
    .step_count_o (step_count),
    .len_err_o    (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Mock cell: one registered stage of y = x + h.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cell_y0 <= '0;
      cell_y1 <= '0;
    end else begin
      cell_y0 <= cell_x0 + cell_h0;
      cell_y1 <= cell_x1 + cell_h1;
    end
  end

  // Output-side ready generator.
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 3) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  // One accepted step: h' = x + h, where h is h_init on the first step of a sequence.
  task automatic model_accept(input logic [W-1:0] x0, input logic [W-1:0] x1, input logic last);
    exp_t e;
    logic [W-1:0] h0, h1;
    h0 = m_first ? h_init0 : m_h0;
    h1 = m_first ? h_init1 : m_h1;
    m_h0 = x0 + h0;
    m_h1 = x1 + h1;
    m_first = 1'b0;
    m_step = (m_step == ML) ? ML : m_step + 1;
    e.h0 = m_h0;
    e.h1 = m_h1;
    e.last = last || (m_step == ML);
    if (!last && m_step == ML) m_len_err = 1'b1;
    e.step = m_step;
    e.lerr = m_len_err;
    q.push_back(e);
    if (e.last) begin
      m_first = 1'b1;
      m_step = 0;
    end
  endtask

  task automatic model_abort();
    q.delete();
    m_first = 1'b1;
    m_step = 0;
    m_len_err = 1'b0;
  endtask

  // Monitor: compares every presented output against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
    end else begin
      chk1("seq_done", seq_done, exp_done);
      if (seq_done) n_done++;
      mon_nd = 1'b0;
      if (out_valid) begin
        chk1("in_ready_during_out", in_ready, 1'b0);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1 with no step pending");
        end else begin
          mon_e = q[0];
          chkw("out_h0", out_h0, mon_e.h0);
          chkw("out_h1", out_h1, mon_e.h1);
          chkw("cell_h0_fb", cell_h0, mon_e.h0);
          chk1("out_last", out_last, mon_e.last);
          chki("step_count", int'(step_count), mon_e.step);
          chk1("len_err", len_err, mon_e.lerr);
          if (out_ready && !abort) begin
            void'(q.pop_front());
            last_h0 = out_h0;
            mon_nd = mon_e.last;
          end
        end
      end
      exp_done = mon_nd;
    end
  end

  // Offers one step from a posedge+1 context; returns at posedge+1 after the accept edge.
  task automatic send_step(input logic [W-1:0] x0, input logic [W-1:0] x1, input logic last);
    int n;
    n = 0;
    in_x0 = x0;
    in_x1 = x1;
    in_last = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!(in_ready && !abort)) begin
      n++;
      if (n > 200) begin
        chki("accept_timeout", n, 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    model_accept(x0, x1, last);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid) begin
      n++;
      if (n > 50) begin
        chki("out_valid_timeout", n, 0);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (q.size() != 0 || out_valid) begin
      n++;
      if (n > 300) begin
        chki("idle_timeout", q.size(), 0);
        return;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t1, t2, t3, d0, len;
    logic seq_last;
    logic [W-1:0] sv_h0, sv_ch0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk1("reset_in_ready", in_ready, 1'b0);
    chk1("reset_out_valid", out_valid, 1'b0);
    chkw("reset_cell_x0", cell_x0, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("post_reset_in_ready", in_ready, 1'b1);
    chk1("post_reset_busy", busy, 1'b0);
    chki("post_reset_step", int'(step_count), 0);
    chk1("post_reset_len_err", len_err, 1'b0);

    // Basic three-step sequence, both sides always ready.
    rdy_mode = 0;
    h_init0 = GRU_ONE;
    h_init1 = '0;
    d0 = n_done;
    @(posedge clk);
    #1;
    send_step(GRU_ONE, '0, 1'b0);
    t1 = acc_cyc;
    send_step(GRU_ONE, '0, 1'b0);
    t2 = acc_cyc;
    send_step(GRU_ONE, '0, 1'b1);
    t3 = acc_cyc;
    wait_idle();
    chki("step_period_1", t2 - t1, LAT + 3);
    chki("step_period_2", t3 - t2, LAT + 3);
    chkw("basic_final_h0", last_h0, GRU_ONE << 2);
    chki("basic_seq_done_count", n_done - d0, 1);
    chk1("basic_busy_after", busy, 1'b0);

    // Output backpressure held for five cycles.
    rdy_mode = 2;
    h_init0 = rnd();
    h_init1 = rnd();
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b0);
    wait_out_valid();
    sv_h0 = out_h0;
    sv_ch0 = cell_h0;
    repeat (5) begin
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chkw("bp_out_h0_stable", out_h0, sv_h0);
      chkw("bp_cell_h0_stable", cell_h0, sv_ch0);
    end
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b1);
    wait_idle();

    // Fresh sequence picks up the new h_init.
    h_init0 = '0;
    h_init1 = '0;
    @(posedge clk);
    #1;
    send_step(GRU_ONE >> 1, '0, 1'b1);
    wait_idle();
    chkw("new_seq_h0", last_h0, GRU_ONE >> 1);

    // Abort during the latency wait.
    h_init0 = rnd();
    h_init1 = rnd();
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b0);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    model_abort();
    @(negedge clk);
    chki("abort_step_count", int'(step_count), 0);
    chk1("abort_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    h_init0 = rnd();
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b1);
    wait_idle();

    // Abort coincident with the final output handshake.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b1);
    wait_out_valid();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    model_abort();
    d0 = n_done;
    repeat (3) @(negedge clk);
    chki("abort_hs_no_done", n_done - d0, 0);
    chk1("abort_hs_out_valid", out_valid, 1'b0);

    // Length limit reached without in_last.
    h_init0 = rnd();
    h_init1 = rnd();
    d0 = n_done;
    @(posedge clk);
    #1;
    for (int i = 0; i < ML; i++) send_step(rnd(), rnd(), 1'b0);
    wait_idle();
    chki("overflow_done_count", n_done - d0, 1);
    chk1("overflow_len_err", len_err, 1'b1);
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b1);
    wait_idle();
    chk1("len_err_sticky", len_err, 1'b1);

    // Asynchronous reset while an output is pending.
    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_step(rnd(), rnd(), 1'b0);
    wait_out_valid();
    #2 reset = 1'b1;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_out_h0", out_h0, '0);
    chk1("rst_out_last", out_last, 1'b0);
    chkw("rst_cell_h0", cell_h0, '0);
    chkw("rst_cell_x1", cell_x1, '0);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_len_err", len_err, 1'b0);
    chki("rst_step", int'(step_count), 0);
    model_abort();
    rdy_mode = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk1("rst_release_in_ready", in_ready, 1'b1);

    // Randomized sequences with random gaps and output stalls.
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 25; s++) begin
      h_init0 = rnd();
      h_init1 = rnd();
      len = $urandom_range(1, 6);
      seq_last = ($urandom % 4) != 0;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom % 3) begin
          @(posedge clk);
          #1;
        end
        send_step(rnd(), rnd(), seq_last && (i == len - 1));
      end
    end
    wait_idle();
    chki("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
